// File: rtl/updown_counter_param.sv
// updown_counter_param
// Parametrised modulo-N up/down counter with parallel load, wrap or saturate
// behaviour at the range ends, registered carry/borrow pulses and a sticky
// overflow flag. The carry output is meant to drive `up` of a following stage
// (with that stage's `en` tied high) to build multi-digit chains.
//
// Parameters:
//   WIDTH     : counter width in bits, 2..32.
//   MAX_COUNT : terminal value, 1 .. 2**WIDTH-1. Count range is 0..MAX_COUNT.
//               Carried as a 64-bit value so the default stays exact at WIDTH=32.
//   SATURATE  : 0 = wrap around at the range ends, 1 = clamp at the range ends.

module updown_counter_param #(
    parameter int unsigned     WIDTH     = 8,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic             down,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             borrow,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf_sticky
);

    // Terminal value at counter width, and zero-extended by one bit so that
    // increments and load-value comparisons cannot overflow when
    // MAX_COUNT = 2**WIDTH-1.
    localparam logic [63:0]    MAX_COUNT_64 = 64'(MAX_COUNT);
    localparam logic [WIDTH-1:0] MAX_VAL    = MAX_COUNT_64[WIDTH-1:0];
    localparam logic [WIDTH:0]   MAX_EXT    = {1'b0, MAX_VAL};

    // State registers and their next-state values.
    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    // Intermediate decode.
    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   inc_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH-1:0] load_val;
    logic             do_up;
    logic             do_down;
    logic             is_max;
    logic             is_min;

    // Range-end decode and request qualification; up and down together cancel.
    always_comb begin
        count_ext = {1'b0, count_q};
        inc_ext   = count_ext + {{WIDTH{1'b0}}, 1'b1};
        load_ext  = {1'b0, data_in};
        load_val  = (load_ext > MAX_EXT) ? MAX_VAL : data_in;
        is_max    = (count_q == MAX_VAL);
        is_min    = (count_q == '0);
        do_up     = en & up & ~down;
        do_down   = en & down & ~up;
    end

    // Next count and carry/borrow: load beats counting, otherwise hold.
    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (do_up) begin
            if (inc_ext > MAX_EXT) begin
                carry_d = 1'b1;
                count_d = SATURATE ? MAX_VAL : '0;
            end else begin
                count_d = inc_ext[WIDTH-1:0];
            end
        end else if (do_down) begin
            if (is_min) begin
                borrow_d = 1'b1;
                count_d  = SATURATE ? '0 : MAX_VAL;
            end else begin
                count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Sticky overflow: a new carry/borrow event wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (carry_d || borrow_d) begin
            ovf_d = 1'b1;
        end else if (clear_flags) begin
            ovf_d = 1'b0;
        end
    end

    // State update with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    // Outputs straight from registers; at_max/at_min decode the count register
    // only, so they have no path from any input.
    assign count      = count_q;
    assign carry      = carry_q;
    assign borrow     = borrow_q;
    assign ovf_sticky = ovf_q;
    assign at_max     = is_max;
    assign at_min     = is_min;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param. Three instances share one input bus:
//   sel 0: WIDTH=4, MAX_COUNT=9,   SATURATE=0
//   sel 1: WIDTH=4, MAX_COUNT=9,   SATURATE=1
//   sel 2: WIDTH=8, MAX_COUNT=255, SATURATE=0
// Each vector names the instance whose outputs are checked after the edge;
// every section starts with a reset so the other instances' states don't matter.
// Expected values are pushed to a queue when a vector is driven and popped
// when the registered result is sampled.

module tb_updown_counter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0, en = 1'b0, load = 1'b0, up = 1'b0, down = 1'b0, clear_flags = 1'b0;
    logic [7:0] data_in = 8'd0;

    logic [3:0] count_a, count_b;
    logic [7:0] count_c;
    logic carry_a, borrow_a, at_max_a, at_min_a, ovf_a;
    logic carry_b, borrow_b, at_max_b, at_min_b, ovf_b;
    logic carry_c, borrow_c, at_max_c, at_min_c, ovf_c;

    updown_counter_param #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) dut_a (
        .clk(clk), .reset(reset), .en(en), .load(load), .up(up), .down(down),
        .data_in(data_in[3:0]), .clear_flags(clear_flags), .count(count_a),
        .carry(carry_a), .borrow(borrow_a), .at_max(at_max_a), .at_min(at_min_a),
        .ovf_sticky(ovf_a));

    updown_counter_param #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) dut_b (
        .clk(clk), .reset(reset), .en(en), .load(load), .up(up), .down(down),
        .data_in(data_in[3:0]), .clear_flags(clear_flags), .count(count_b),
        .carry(carry_b), .borrow(borrow_b), .at_max(at_max_b), .at_min(at_min_b),
        .ovf_sticky(ovf_b));

    updown_counter_param #(.WIDTH(8), .MAX_COUNT(255), .SATURATE(1'b0)) dut_c (
        .clk(clk), .reset(reset), .en(en), .load(load), .up(up), .down(down),
        .data_in(data_in), .clear_flags(clear_flags), .count(count_c),
        .carry(carry_c), .borrow(borrow_c), .at_max(at_max_c), .at_min(at_min_c),
        .ovf_sticky(ovf_c));

    typedef struct {
        int         sel;
        logic       rst, ld, en, up, dn;
        logic [7:0] din;
        logic       clr;
        logic [7:0] cnt;
        logic       cy, bw, mx, mn, ov;
    } vec_t;

    typedef struct {
        int         sel;
        int         idx;
        logic [7:0] cnt;
        logic       cy, bw, mx, mn, ov;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    function automatic vec_t mk(int sel, logic rst, logic ld, logic e, logic u, logic d,
                                logic [7:0] din, logic clr, logic [7:0] cnt,
                                logic cy, logic bw, logic mx, logic mn, logic ov);
        vec_t v;
        v.sel = sel; v.rst = rst; v.ld = ld; v.en = e; v.up = u; v.dn = d;
        v.din = din; v.clr = clr; v.cnt = cnt;
        v.cy = cy; v.bw = bw; v.mx = mx; v.mn = mn; v.ov = ov;
        return v;
    endfunction

    task automatic cmp(string name, int idx, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one vector at the falling edge, then check right after the rising edge.
    task automatic step(vec_t v);
        exp_t e, g;
        logic [7:0] a_cnt;
        logic a_cy, a_bw, a_mx, a_mn, a_ov;
        @(negedge clk);
        reset = v.rst; load = v.ld; en = v.en; up = v.up; down = v.dn;
        data_in = v.din; clear_flags = v.clr;
        e.sel = v.sel; e.idx = step_no; e.cnt = v.cnt;
        e.cy = v.cy; e.bw = v.bw; e.mx = v.mx; e.mn = v.mn; e.ov = v.ov;
        sb.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard step %0d: got empty queue expected entry", step_no);
        end else begin
            checks--;
            g = sb.pop_front();
            case (g.sel)
                0: begin a_cnt = {4'd0, count_a}; a_cy = carry_a; a_bw = borrow_a;
                         a_mx = at_max_a; a_mn = at_min_a; a_ov = ovf_a; end
                1: begin a_cnt = {4'd0, count_b}; a_cy = carry_b; a_bw = borrow_b;
                         a_mx = at_max_b; a_mn = at_min_b; a_ov = ovf_b; end
                default: begin a_cnt = count_c; a_cy = carry_c; a_bw = borrow_c;
                         a_mx = at_max_c; a_mn = at_min_c; a_ov = ovf_c; end
            endcase
            $display("step %0d sel %0d: count %0d carry %0b borrow %0b at_max %0b at_min %0b ovf %0b",
                     g.idx, g.sel, a_cnt, a_cy, a_bw, a_mx, a_mn, a_ov);
            cmp("count",      g.idx, a_cnt,        g.cnt);
            cmp("carry",      g.idx, {7'd0, a_cy}, {7'd0, g.cy});
            cmp("borrow",     g.idx, {7'd0, a_bw}, {7'd0, g.bw});
            cmp("at_max",     g.idx, {7'd0, a_mx}, {7'd0, g.mx});
            cmp("at_min",     g.idx, {7'd0, a_mn}, {7'd0, g.mn});
            cmp("ovf_sticky", g.idx, {7'd0, a_ov}, {7'd0, g.ov});
        end
    endtask

    initial begin
        //                sel rst ld en up dn din clr | cnt cy bw mx mn ov
        // Wrap mode, MAX_COUNT=9: count up through the terminal value.
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 7,  0,  7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,  0,  8, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,  0,  9, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,  0,  0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,  0,  1, 0, 0, 0, 0, 1));
        // Count down through zero.
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1,  0,  1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0,  0,  0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0,  0,  9, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0,  0,  8, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1,  8, 0, 0, 0, 0, 0));
        // Priority: reset > load > up/down; up and down together hold.
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 5,  0,  5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 6,  0,  0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 6,  0,  6, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0,  0,  6, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,  0,  7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,  0,  8, 0, 0, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // en=0 with up held: five cycles of no movement and no carry.
        for (int k = 0; k < 5; k++) step(mk(0, 0, 0, 0, 1, 0, 0, 0, 8, 0, 0, 0, 0, 0));

        // Carry coincident with clear_flags keeps the flag; clear alone drops it.
        step(mk(0, 0, 0, 1, 1, 0, 0,  0,  9, 0, 0, 1, 0, 0));
        step(mk(0, 0, 0, 1, 1, 0, 0,  1,  0, 1, 0, 0, 1, 1));
        step(mk(0, 0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 0, 1, 0));
        // Load above MAX clamps; load at MAX with up high gives no carry.
        step(mk(0, 0, 1, 0, 0, 0, 12, 0,  9, 0, 0, 1, 0, 0));
        step(mk(0, 0, 1, 1, 1, 0, 9,  0,  9, 0, 0, 1, 0, 0));
        step(mk(0, 0, 0, 1, 1, 0, 0,  0,  0, 1, 0, 0, 1, 1));
        // Reset while a carry would occur drops it.
        step(mk(0, 0, 1, 0, 0, 0, 9,  0,  9, 0, 0, 1, 0, 1));
        step(mk(0, 1, 0, 1, 1, 0, 0,  0,  0, 0, 0, 0, 1, 0));

        // Saturate mode: clamp at both ends, carry/borrow every cycle.
        step(mk(1, 1, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 1, 0));
        step(mk(1, 0, 1, 0, 0, 0, 15, 0,  9, 0, 0, 1, 0, 0));
        step(mk(1, 0, 0, 1, 1, 0, 0,  0,  9, 1, 0, 1, 0, 1));
        step(mk(1, 0, 0, 1, 1, 0, 0,  0,  9, 1, 0, 1, 0, 1));
        step(mk(1, 0, 0, 1, 0, 1, 0,  0,  8, 0, 0, 0, 0, 1));
        step(mk(1, 0, 1, 0, 0, 0, 0,  0,  0, 0, 0, 0, 1, 1));
        step(mk(1, 0, 0, 1, 0, 1, 0,  0,  0, 0, 1, 0, 1, 1));
        step(mk(1, 0, 0, 1, 0, 1, 0,  0,  0, 0, 1, 0, 1, 1));
        step(mk(1, 0, 0, 1, 1, 0, 0,  0,  1, 0, 0, 0, 0, 1));

        // Full-range 8-bit wrap.
        step(mk(2, 1, 0, 0, 0, 0, 0,   0,   0, 0, 0, 0, 1, 0));
        step(mk(2, 0, 1, 0, 0, 0, 255, 0, 255, 0, 0, 1, 0, 0));
        step(mk(2, 0, 0, 1, 1, 0, 0,   0,   0, 1, 0, 0, 1, 1));
        step(mk(2, 0, 0, 1, 0, 1, 0,   0, 255, 0, 1, 1, 0, 1));
        step(mk(2, 0, 0, 1, 0, 1, 0,   0, 254, 0, 0, 0, 0, 1));
        step(mk(2, 0, 1, 0, 0, 0, 200, 0, 200, 0, 0, 0, 0, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
